// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with a valid/ready input and registered Z/C/N flags.
// Define ALU_SEQ_MUL_EN to make opcode 7 a multi-cycle shift-add MUL; otherwise opcode 7 is PASS B.
module alu_seq #(
  parameter int WIDTH = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       alu_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             out_valid,
  output logic             z,
  output logic             c,
  output logic             n
);

  logic [WIDTH-1:0] res;
  logic             carry;
  logic             accept;
  logic             is_mul;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (alu_sel)
      3'd0:    {carry, res} = {1'b0, in_a} + {1'b0, in_b};
      3'd1: begin
        res   = in_a - in_b;
        carry = in_a < in_b;
      end
      3'd2:    res = in_a & in_b;
      3'd3:    res = in_a | in_b;
      3'd4:    res = in_a ^ in_b;
      3'd5:    res = ~in_a;
      3'd6: begin
        res   = {in_a[WIDTH-2:0], 1'b0};
        carry = in_a[WIDTH-1];
      end
      default: res = in_b;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;

  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               mul_last;

  assign is_mul   = alu_sel == 3'd7;
  assign in_ready = state == IDLE;
  assign mul_last = (state == MUL) && (cnt == CNT_W'(1));
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL;
      MUL:     if (mul_last)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One multiplier bit per edge; the last step's sum is the full product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, in_a};
      mplier <= in_b;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH);
    end else if (state == MUL) begin
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      acc    <= acc_nxt;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out    <= '0;
      alu_out_hi <= '0;
      z          <= 1'b0;
      c          <= 1'b0;
      n          <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        alu_out    <= res;
        alu_out_hi <= '0;
        z          <= res == '0;
        c          <= carry;
        n          <= res[WIDTH-1];
        out_valid  <= 1'b1;
      end else if (mul_last) begin
        {alu_out_hi, alu_out} <= acc_nxt;
        z         <= acc_nxt[WIDTH-1:0] == '0;
        c         <= |acc_nxt[2*WIDTH-1:WIDTH];
        n         <= acc_nxt[WIDTH-1];
        out_valid <= 1'b1;
      end
    end
  end
`else
  assign is_mul     = 1'b0;
  assign in_ready   = 1'b1;
  assign alu_out_hi = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out   <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
      n         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        alu_out   <= res;
        z         <= res == '0;
        c         <= carry;
        n         <= res[WIDTH-1];
        out_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit instance for all ops and a 16-bit instance for wrap cases.
// The MUL or PASS B section is chosen by ALU_SEQ_MUL_EN, matching the design build.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a, b;
  logic [2:0]  sel;
  logic        vld;
  logic        rdy, ov, z, c, n;
  logic [7:0]  out, out_hi;

  logic [15:0] a16, b16;
  logic [2:0]  sel16;
  logic        vld16;
  logic        rdy16, ov16, z16, c16, n16;
  logic [15:0] out16, out_hi16;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_a(a), .in_b(b), .alu_sel(sel), .in_valid(vld),
    .in_ready(rdy), .alu_out(out), .alu_out_hi(out_hi), .out_valid(ov),
    .z(z), .c(c), .n(n)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_a(a16), .in_b(b16), .alu_sel(sel16), .in_valid(vld16),
    .in_ready(rdy16), .alu_out(out16), .alu_out_hi(out_hi16), .out_valid(ov16),
    .z(z16), .c(c16), .n(n16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] is, input logic iv);
    a = ia; b = ib; sel = is; vld = iv;
  endtask

  // Packs result and flags so one compare covers a whole result cycle.
  function automatic logic [31:0] pk(input logic [7:0] hi, input logic [7:0] lo,
                                     input logic fv, input logic fz, input logic fc, input logic fn);
    return {8'h0, hi, lo, 4'h0, fv, fz, fc, fn};
  endfunction

  logic [31:0] obs;
  always_comb obs = pk(out_hi, out, ov, z, c, n);

  initial begin
    issue(8'h0, 8'h0, 3'd0, 1'b0);
    a16 = '0; b16 = '0; sel16 = 3'd0; vld16 = 1'b0;

    tick(); tick();
    chk("reset_out", obs, pk(8'h00, 8'h00, 0, 0, 0, 0));
    chk("reset_rdy", rdy, 1'b1);
    chk("reset_out16", {out_hi16, out16, ov16, z16, c16, n16}, 32'h0);
    rst_n = 1'b1;

    issue(8'd200, 8'd100, 3'd0, 1'b1); tick();
    chk("add_200_100", obs, pk(8'h00, 8'h2C, 1, 0, 1, 0));
    issue(8'd0, 8'd0, 3'd0, 1'b0); tick();
    chk("add_hold", obs, pk(8'h00, 8'h2C, 0, 0, 1, 0));

    issue(8'd5, 8'd5, 3'd1, 1'b1); tick();
    chk("sub_5_5", obs, pk(8'h00, 8'h00, 1, 1, 0, 0));
    issue(8'd6, 8'd9, 3'd1, 1'b1); tick();
    chk("sub_6_9", obs, pk(8'h00, 8'hFD, 1, 0, 1, 1));
    issue(8'd0, 8'd0, 3'd0, 1'b0); tick();
    chk("sub_hold", obs, pk(8'h00, 8'hFD, 0, 0, 1, 1));

    issue(8'hC3, 8'h5A, 3'd2, 1'b1); tick();
    chk("and", obs, pk(8'h00, 8'h42, 1, 0, 0, 0));
    issue(8'hC3, 8'h5A, 3'd3, 1'b1); tick();
    chk("or", obs, pk(8'h00, 8'hDB, 1, 0, 0, 1));
    issue(8'hC3, 8'h5A, 3'd4, 1'b1); tick();
    chk("xor", obs, pk(8'h00, 8'h99, 1, 0, 0, 1));
    issue(8'hC3, 8'h5A, 3'd5, 1'b1); tick();
    chk("not", obs, pk(8'h00, 8'h3C, 1, 0, 0, 0));
    issue(8'hC3, 8'h00, 3'd6, 1'b1); tick();
    chk("shl_c3", obs, pk(8'h00, 8'h86, 1, 0, 1, 1));
    issue(8'h41, 8'h00, 3'd6, 1'b1); tick();
    chk("shl_41", obs, pk(8'h00, 8'h82, 1, 0, 0, 1));
    issue(8'hFF, 8'h01, 3'd0, 1'b1); tick();
    chk("add_wrap8", obs, pk(8'h00, 8'h00, 1, 1, 1, 0));

    issue(8'd6, 8'd9, 3'd1, 1'b1); tick();
    rst_n = 1'b0;
    issue(8'd0, 8'd0, 3'd0, 1'b0); tick();
    chk("reset_after_op", obs, pk(8'h00, 8'h00, 0, 0, 0, 0));
    chk("reset_after_op_rdy", rdy, 1'b1);
    rst_n = 1'b1;

`ifdef ALU_SEQ_MUL_EN
    issue(8'd200, 8'd200, 3'd7, 1'b1); tick();
    chk("mul_accept_rdy", rdy, 1'b0);
    chk("mul_accept_ov", ov, 1'b0);
    // A held ADD 1+1 must wait until the multiply has finished.
    issue(8'd1, 8'd1, 3'd0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("mul_busy_%0d", i), {rdy, ov}, 2'b00);
    end
    tick();
    chk("mul_200_200", obs, pk(8'h9C, 8'h40, 1, 0, 1, 0));
    chk("mul_done_rdy", rdy, 1'b1);
    tick();
    chk("add_after_mul", obs, pk(8'h00, 8'h02, 1, 0, 0, 0));
    issue(8'd0, 8'd0, 3'd0, 1'b0); tick();

    issue(8'd7, 8'd9, 3'd7, 1'b1); tick();
    issue(8'd0, 8'd0, 3'd0, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0; tick();
    chk("mul_abort", obs, pk(8'h00, 8'h00, 0, 0, 0, 0));
    chk("mul_abort_rdy", rdy, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("mul_abort_quiet_%0d", i), ov, 1'b0);
    end
    issue(8'd7, 8'd9, 3'd7, 1'b1); tick();
    issue(8'd0, 8'd0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("mul_7_9_early", ov, 1'b0);
    tick();
    chk("mul_7_9", obs, pk(8'h00, 8'd63, 1, 0, 0, 0));
`else
    issue(8'hC3, 8'h00, 3'd6, 1'b1); tick();
    issue(8'h11, 8'h5A, 3'd7, 1'b1); tick();
    chk("pass_b", obs, pk(8'h00, 8'h5A, 1, 0, 0, 0));
    chk("pass_b_rdy", rdy, 1'b1);
    issue(8'h11, 8'hA5, 3'd7, 1'b1); tick();
    chk("pass_b_b2b", obs, pk(8'h00, 8'hA5, 1, 0, 0, 1));
    issue(8'd0, 8'd0, 3'd0, 1'b0); tick();
`endif

    a16 = 16'hFFFF; b16 = 16'h0001; sel16 = 3'd0; vld16 = 1'b1; tick();
    chk("add16_wrap", {out_hi16, out16, 4'h0, ov16, z16, c16, n16}, {16'h0, 16'h0, 8'h0E} >> 0);
    a16 = 16'h0001; b16 = 16'h0002; sel16 = 3'd1; tick();
    chk("sub16_borrow", {out_hi16, out16, 4'h0, ov16, z16, c16, n16}, {16'h0, 16'hFFFF, 8'h0B} >> 0);
    vld16 = 1'b0; tick();
    chk("sub16_hold", {ov16, c16, n16}, 3'b011);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
